// File: rtl/cci_mpf_csrs_pkg.sv
// Shared widths and index type for the MPF event counter bank.
package cci_mpf_csrs_pkg;
    localparam int MPF_EVENT_CTR_MAX_WIDTH = 64;
    localparam int MPF_EVENT_CTR_MAX_IDX_W = 6;

    typedef logic [MPF_EVENT_CTR_MAX_IDX_W-1:0] t_mpf_event_ctr_idx;
endpackage

// File: rtl/cci_mpf_event_ctr.sv
// One live event counter: clear-then-count, wrap by default or saturate
// when MPF_EVENT_CTR_SATURATE_EN is defined.
module cci_mpf_event_ctr #(
    parameter int CTR_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CTR_WIDTH-1:0] value
);
    logic [CTR_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            // A clear and an increment landing together leave a count of one.
            cnt <= inc ? CTR_WIDTH'(1) : '0;
        end else if (inc) begin
`ifdef MPF_EVENT_CTR_SATURATE_EN
            if (cnt != '1)
                cnt <= cnt + CTR_WIDTH'(1);
`else
            cnt <= cnt + CTR_WIDTH'(1);
`endif
        end
    end

    assign value = cnt;
endmodule

// File: rtl/cci_mpf_event_ctr_bank.sv
// Bank of N_EVENTS event counters with a snapshot shadow bank and a 1-cycle
// read port. Saturation is enabled by MPF_EVENT_CTR_SATURATE_EN.
module cci_mpf_event_ctr_bank
    import cci_mpf_csrs_pkg::*;
#(
    parameter int N_EVENTS  = 16,
    parameter int CTR_WIDTH = 48,
    localparam int IDX_W    = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_EVENTS-1:0] events_in,
    input  logic                clr_valid,
    input  logic [IDX_W-1:0]    clr_idx,
    input  logic                clr_all,
    input  logic                snap_req,
    input  logic                rd_req_valid,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic                rd_snap,
    output logic                rd_rsp_valid,
    output logic [63:0]         rd_rsp_data
);
    logic [N_EVENTS-1:0]                events_q;
    logic [N_EVENTS-1:0]                clr_vec;
    logic [N_EVENTS-1:0][CTR_WIDTH-1:0] live;
    logic [N_EVENTS-1:0][CTR_WIDTH-1:0] shadow;
    logic [CTR_WIDTH-1:0]               rd_sel;
    t_mpf_event_ctr_idx                 clr_idx_x;
    t_mpf_event_ctr_idx                 rd_idx_x;

    assign clr_idx_x = t_mpf_event_ctr_idx'(clr_idx);
    assign rd_idx_x  = t_mpf_event_ctr_idx'(rd_idx);

    always_ff @(posedge clk) begin
        if (reset)
            events_q <= '0;
        else
            events_q <= events_in;
    end

    // Out-of-range indices match no counter, so they clear nothing.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N_EVENTS; i++)
            clr_vec[i] = clr_all | (clr_valid && (clr_idx_x == t_mpf_event_ctr_idx'(i)));
    end

    for (genvar g = 0; g < N_EVENTS; g++) begin : g_ctr
        cci_mpf_event_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (events_q[g]),
            .clr   (clr_vec[g]),
            .value (live[g])
        );
    end

    // Shadow copies pre-commit values and ignores clears.
    always_ff @(posedge clk) begin
        if (reset)
            shadow <= '0;
        else if (snap_req)
            shadow <= live;
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_EVENTS; i++)
            if (rd_idx_x == t_mpf_event_ctr_idx'(i))
                rd_sel = rd_snap ? shadow[i] : live[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else begin
            rd_rsp_valid <= rd_req_valid;
            rd_rsp_data  <= 64'(rd_sel);
        end
    end
endmodule

// File: tb/tb_cci_mpf_event_ctr_bank.sv
// Directed bench: 16x48 bank for main function, 12x4 bank for limit/range.
module tb_cci_mpf_event_ctr_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] events_in;
    logic        clr_valid, clr_all, snap_req, rd_req_valid, rd_snap;
    logic [3:0]  clr_idx, rd_idx;
    logic        rd_rsp_valid;
    logic [63:0] rd_rsp_data;

    logic [11:0] s_events;
    logic        s_clr_valid, s_clr_all, s_snap_req, s_rd_req_valid, s_rd_snap;
    logic [3:0]  s_clr_idx, s_rd_idx;
    logic        s_rd_rsp_valid;
    logic [63:0] s_rd_rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cci_mpf_event_ctr_bank #(.N_EVENTS(16), .CTR_WIDTH(48)) dut (
        .clk(clk), .reset(reset), .events_in(events_in),
        .clr_valid(clr_valid), .clr_idx(clr_idx), .clr_all(clr_all),
        .snap_req(snap_req), .rd_req_valid(rd_req_valid), .rd_idx(rd_idx),
        .rd_snap(rd_snap), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data)
    );

    cci_mpf_event_ctr_bank #(.N_EVENTS(12), .CTR_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .events_in(s_events),
        .clr_valid(s_clr_valid), .clr_idx(s_clr_idx), .clr_all(s_clr_all),
        .snap_req(s_snap_req), .rd_req_valid(s_rd_req_valid), .rd_idx(s_rd_idx),
        .rd_snap(s_rd_snap), .rd_rsp_valid(s_rd_rsp_valid), .rd_rsp_data(s_rd_rsp_data)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_big(input logic snap, input logic [3:0] idx,
                          output logic v, output logic [63:0] d);
        rd_req_valid = 1'b1; rd_snap = snap; rd_idx = idx;
        tick();
        v = rd_rsp_valid; d = rd_rsp_data;
        rd_req_valid = 1'b0;
    endtask

    task automatic rd_small(input logic [3:0] idx, output logic v, output logic [63:0] d);
        s_rd_req_valid = 1'b1; s_rd_snap = 1'b0; s_rd_idx = idx;
        tick();
        v = s_rd_rsp_valid; d = s_rd_rsp_data;
        s_rd_req_valid = 1'b0;
    endtask

    task automatic clear_big();
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
    endtask

    task automatic test_reset();
        logic v; logic [63:0] d;
        reset = 1'b1; events_in = '1; s_events = '1;
        rd_req_valid = 1'b1; rd_idx = 4'd0;
        tick(3);
        n_cmp++;
        if (rd_rsp_valid !== 1'b0 || rd_rsp_data !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b data=%0d want valid=0 data=0", rd_rsp_valid, rd_rsp_data);
        end
        reset = 1'b0; events_in = '0; s_events = '0; rd_req_valid = 1'b0;
        tick(2);
        rd_big(1'b0, 4'd0, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_events_dropped: valid=%b data=%0d want valid=1 data=0", v, d);
        end
    endtask

    task automatic test_burst();
        logic v; logic [63:0] d;
        events_in = 16'h0008;
        tick(10);
        events_in = '0;
        tick(2);
        rd_big(1'b0, 4'd3, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd10) begin
            n_bad++;
            $display("FAIL burst_idx3: valid=%b data=%0d want valid=1 data=10", v, d);
        end
    endtask

    task automatic test_clr_count();
        logic v; logic [63:0] d;
        clear_big();
        events_in = 16'h0020;
        tick(7);
        events_in = '0;
        tick(2);
        rd_big(1'b0, 4'd5, v, d);
        n_cmp++;
        if (d !== 64'd7) begin
            n_bad++;
            $display("FAIL clr_count_pre: data=%0d want 7", d);
        end
        events_in = 16'h0020;
        tick();
        events_in = '0; clr_valid = 1'b1; clr_idx = 4'd5;
        tick();
        clr_valid = 1'b0;
        tick();
        rd_big(1'b0, 4'd5, v, d);
        n_cmp++;
        if (d !== 64'd1) begin
            n_bad++;
            $display("FAIL clr_and_count: data=%0d want 1", d);
        end
    endtask

    task automatic test_snapshot();
        logic v; logic [63:0] d;
        clear_big();
        events_in = 16'h0001;
        tick(4);
        events_in = '0;
        tick(2);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        events_in = 16'h0001;
        tick(3);
        events_in = '0;
        tick(2);
        clr_all = 1'b1; clr_valid = 1'b1; clr_idx = 4'd5;
        tick();
        clr_all = 1'b0; clr_valid = 1'b0;
        rd_big(1'b1, 4'd0, v, d);
        n_cmp++;
        if (d !== 64'd4) begin
            n_bad++;
            $display("FAIL snap_shadow: data=%0d want 4", d);
        end
        rd_big(1'b0, 4'd0, v, d);
        n_cmp++;
        if (d !== 64'd0) begin
            n_bad++;
            $display("FAIL snap_live_cleared: data=%0d want 0", d);
        end
    endtask

    task automatic test_back_to_back();
        clear_big();
        events_in = '1;
        tick(3);
        events_in = '0;
        tick(2);
        rd_req_valid = 1'b1; rd_snap = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            tick();
            n_cmp++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'd3) begin
                n_bad++;
                $display("FAIL all_events_idx%0d: valid=%b data=%0d want valid=1 data=3", i, rd_rsp_valid, rd_rsp_data);
            end
        end
        rd_req_valid = 1'b0;
    endtask

    task automatic test_limit();
        logic v; logic [63:0] d;
        logic [63:0] exp;
`ifdef MPF_EVENT_CTR_SATURATE_EN
        exp = 64'd15;
`else
        exp = 64'd1;
`endif
        s_events = 12'h004;
        tick(17);
        s_events = '0;
        tick(2);
        rd_small(4'd2, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== exp) begin
            n_bad++;
            $display("FAIL limit_17_events: valid=%b data=%0d want valid=1 data=%0d", v, d, exp);
        end
        s_clr_valid = 1'b1; s_clr_idx = 4'd13;
        tick();
        s_clr_valid = 1'b0;
        rd_small(4'd2, v, d);
        n_cmp++;
        if (d !== exp) begin
            n_bad++;
            $display("FAIL clr_out_of_range: data=%0d want %0d", d, exp);
        end
    endtask

    task automatic test_out_of_range();
        logic v; logic [63:0] d;
        s_events = '1;
        tick(2);
        s_events = '0;
        tick(2);
        rd_small(4'd12, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd0) begin
            n_bad++;
            $display("FAIL rd_idx12: valid=%b data=%0d want valid=1 data=0", v, d);
        end
        rd_small(4'd15, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd0) begin
            n_bad++;
            $display("FAIL rd_idx15: valid=%b data=%0d want valid=1 data=0", v, d);
        end
        rd_small(4'd11, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd2) begin
            n_bad++;
            $display("FAIL rd_idx11: valid=%b data=%0d want valid=1 data=2", v, d);
        end
    endtask

    task automatic test_reset_read();
        reset = 1'b1; rd_req_valid = 1'b1; rd_idx = 4'd0; rd_snap = 1'b0;
        tick();
        n_cmp++;
        if (rd_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_read_dropped: valid=%b want 0", rd_rsp_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            rd_snap = i[0];
            tick();
            n_cmp++;
            if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 64'd0) begin
                n_bad++;
                $display("FAIL post_reset_idx%0d: valid=%b data=%0d want valid=1 data=0", i, rd_rsp_valid, rd_rsp_data);
            end
        end
        rd_req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; events_in = '0; clr_valid = 1'b0; clr_idx = '0; clr_all = 1'b0;
        snap_req = 1'b0; rd_req_valid = 1'b0; rd_idx = '0; rd_snap = 1'b0;
        s_events = '0; s_clr_valid = 1'b0; s_clr_idx = '0; s_clr_all = 1'b0;
        s_snap_req = 1'b0; s_rd_req_valid = 1'b0; s_rd_idx = '0; s_rd_snap = 1'b0;
        test_reset();
        test_burst();
        test_clr_count();
        test_snapshot();
        test_back_to_back();
        test_limit();
        test_out_of_range();
        test_reset_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
